// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADD3_THRESH = 5;
  localparam int unsigned ADD3_VAL    = 3;

  // Decimal digits needed for 2^bin_w-1: floor(bin_w*log10(2))+1.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted_c
);

  always_comb begin
    adjusted_c = digit;
    if (digit >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      adjusted_c = digit + BCD_DIGIT_W'(ADD3_VAL);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional two's-complement input mode: define BCD_SIGNED_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BIN_W-1:0]                bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcdout,
  output logic                            ovf
`ifdef BCD_SIGNED_EN
  ,
  output logic                            sign
`endif
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  // Overflow is only reachable when the digit count is too small for BIN_W.
  localparam bit CAN_OVF = (DIGITS < min_digits(BIN_W));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic               sticky_q, sticky_d;
  logic               busy_d, done_d, ovf_d;
  logic [BCD_W-1:0]   bcdout_d;

  logic [BIN_W-1:0]   load_c;
  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   scr_shift_c;
  logic [BIN_W-1:0]   bin_shift_c;
  logic               shift_out_c;

`ifdef BCD_SIGNED_EN
  logic neg_c;
  logic sign_cap_q, sign_cap_d, sign_d;

  assign neg_c  = bin[BIN_W-1];
  assign load_c = neg_c ? (~bin + BIN_W'(1)) : bin;
`else
  assign load_c = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit      (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted_c (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {scratch, binary} shifted left by one after the per-digit adjust.
  assign shift_out_c = adj_c[BCD_W-1];
  assign scr_shift_c = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
  assign bin_shift_c = {bin_q[BIN_W-2:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    sticky_d = sticky_q;
    busy_d   = busy;
    done_d   = 1'b0;
    bcdout_d = bcdout;
    ovf_d    = ovf;
`ifdef BCD_SIGNED_EN
    sign_cap_d = sign_cap_q;
    sign_d     = sign;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = load_c;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef BCD_SIGNED_EN
          sign_cap_d = neg_c;
`endif
        end
      end
      SHIFT: begin
        scr_d    = scr_shift_c;
        bin_d    = bin_shift_c;
        sticky_d = sticky_q | (CAN_OVF && shift_out_c);
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcdout_d = scr_shift_c;
          ovf_d    = sticky_d;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
`ifdef BCD_SIGNED_EN
          sign_d = sign_cap_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      scr_q    <= '0;
      sticky_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcdout   <= '0;
      ovf      <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_cap_q <= 1'b0;
      sign       <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      sticky_q <= sticky_d;
      busy     <= busy_d;
      done     <= done_d;
      bcdout   <= bcdout_d;
      ovf      <= ovf_d;
`ifdef BCD_SIGNED_EN
      sign_cap_q <= sign_cap_d;
      sign       <= sign_d;
`endif
    end
  end

endmodule
